uart_boot_ctrl: RTL and testbench
=================================

// Module: uart_boot_ctrl
// PURPOSE
//  Sequences program download from the UART word receiver into CPU instruction memory.
//  Parses a framed image (magic, length, payload, checksum) and drives the imem write port.
//  Holds the CPU in reset until the image is complete and verified, then releases it.
//  Sits between uart (io_word_valid/io_word_packet) and pipeline (imem_en/imem_data_in/write_address/reset_n).
// PARAMETERS
//  BOOT_MAGIC        32'hB007_10AD  frame start word
//  IMEM_DEPTH_WORDS  256            max payload words accepted
//  BASE_ADDR         32'h0000_0000  byte address of first payload word
//  TIMEOUT_CYCLES    50_000_000     max idle cycles between words once a frame has started
//  RELEASE_DELAY     16             cycles cpu_rstn stays low after checksum pass
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   asynchronous active-low reset
//  io_word_valid  in   1   one-cycle strobe: io_word_packet holds a new word
//  io_word_packet in   32  received word
//  imem_en        out  1   instruction-memory write enable (one cycle per payload word)
//  imem_data_in   out  32  write data
//  write_address  out  32  byte write address
//  cpu_rstn       out  1   CPU reset, active low
//  load_busy      out  1   high in LEN/LOAD/CHECK/RELEASE
//  load_error     out  1   high in ERROR
//  words_loaded   out  16  payload words written in current frame
//  state_dbg      out  3   current state encoding
// BEHAVIOUR
//  Reset: state=IDLE, imem_en=0, imem_data_in=0, write_address=BASE_ADDR, cpu_rstn=0, load_busy=0, load_error=0, words_loaded=0, internal len/csum/timer=0.
//  All outputs registered. imem_en/imem_data_in/write_address are valid 1 cycle after the accepted io_word_valid.
//  States:
//   IDLE:    word==BOOT_MAGIC -> LEN. Other words are ignored.
//   LEN:     word -> len. len==0 or len>IMEM_DEPTH_WORDS -> ERROR; otherwise -> LOAD with csum=0, words_loaded=0.
//   LOAD:    each word: imem_en=1, imem_data_in=word, write_address=BASE_ADDR+4*words_loaded, csum+=word (mod 2^32), words_loaded++. After word number len -> CHECK.
//   CHECK:   word==csum -> RELEASE; mismatch -> ERROR.
//   RELEASE: counts RELEASE_DELAY cycles, ignores words, then -> RUN.
//   RUN:     cpu_rstn=1. word==BOOT_MAGIC -> LEN, and cpu_rstn drops to 0 on the next cycle (reload). Other words are ignored.
//   ERROR:   cpu_rstn=0, load_error=1. word==BOOT_MAGIC -> LEN (restart). Other words are ignored.
//  cpu_rstn is 1 only in RUN; asserted low in every other state.
//  Timeout: timer clears on every accepted word and counts in LEN/LOAD/CHECK.
//   Timer reaching TIMEOUT_CYCLES-1 -> ERROR.
//   A word arriving in the same cycle as the timeout wins; the timer clears.
//  Address wrap cannot occur: len is bounded by IMEM_DEPTH_WORDS. write_address holds its last value outside LOAD.
//  A magic value inside LOAD is treated as payload; there is no resync mid-frame.
//  Async reset mid-load: returns to IDLE immediately. Partially written imem is left as-is; the CPU stays in reset.
//  imem_en is never high outside the cycle after a LOAD-state word.
// STRUCTURE
//  common package: typedef enum logic [2:0] {BOOT_IDLE, BOOT_LEN, BOOT_LOAD, BOOT_CHECK, BOOT_RELEASE, BOOT_RUN, BOOT_ERROR} boot_state_t; localparam BOOT_MAGIC.
//  Single always_ff FSM plus datapath registers; no sub-module. The timeout counter is inline.
//  Top level: replaces the free-running write_address counter. pipeline.reset_n = cpu_rstn & rstn_cpu.
// TESTING
//  T1: MAGIC, 3, 0x11, 0x22, 0x33, 0x66
//      -> imem writes at 0x0/0x4/0x8; cpu_rstn=1 exactly 16 cycles after the checksum word; state RUN.
//  T2: MAGIC, 2, 0xA, 0xB, 0x0 (bad checksum)
//      -> load_error=1, cpu_rstn=0. A following MAGIC, 1, 0x5, 0x5 -> RUN.
//  T3: MAGIC, 0 -> ERROR.  MAGIC, 257 -> ERROR.  No imem_en pulses in either case.
//  T4: MAGIC, 4, 0x1, then silence for TIMEOUT_CYCLES (bench uses 100)
//      -> ERROR at cycle 100; words_loaded=1.
//  T5: full load to RUN, then MAGIC, 1, 0x7, 0x7
//      -> cpu_rstn low the cycle after the MAGIC; rewrite at 0x0; release again.
//  T6: reset_n low during LOAD word 2 of 4
//      -> all outputs return to reset values asynchronously; the next frame loads normally from 0x0.

Source files
------------

// File: rtl/uart_boot_ctrl_pkg.sv
// Boot loader shared types and constants.
// Frame: magic, length, payload words, checksum.
package uart_boot_ctrl_pkg;

    typedef enum logic [2:0] {
        BOOT_IDLE,
        BOOT_LEN,
        BOOT_LOAD,
        BOOT_CHECK,
        BOOT_RELEASE,
        BOOT_RUN,
        BOOT_ERROR
    } boot_state_t;

    localparam logic [31:0] BOOT_MAGIC = 32'hB007_10AD;
    localparam int unsigned IMEM_DEPTH_WORDS = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int unsigned TIMEOUT_CYCLES = 50_000_000;
    localparam int unsigned RELEASE_DELAY = 16;

endpackage

// File: rtl/uart_boot_ctrl_if.sv
// Received-word strobe from the UART word receiver.
// master = receiver side, slave = boot controller.
interface uart_boot_ctrl_if;

    logic        io_word_valid;
    logic [31:0] io_word_packet;

    modport master (
        output io_word_valid,
        output io_word_packet
    );

    modport slave (
        input io_word_valid,
        input io_word_packet
    );

endinterface

// File: rtl/uart_boot_ctrl.sv
// Boot controller: parses a framed image from the UART,
// writes it to imem and releases the CPU once verified.
module uart_boot_ctrl
    import uart_boot_ctrl_pkg::*;
#(
    parameter logic [31:0] MAGIC       = BOOT_MAGIC,
    parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter logic [31:0] BASE        = BASE_ADDR,
    parameter int unsigned TIMEOUT     = TIMEOUT_CYCLES,
    parameter int unsigned REL_DELAY   = RELEASE_DELAY
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_boot_ctrl_if.slave   uart,
    output logic              imem_en,
    output logic [31:0]       imem_data_in,
    output logic [31:0]       write_address,
    output logic              cpu_rstn,
    output logic              load_busy,
    output logic              load_error,
    output logic [15:0]       words_loaded,
    output logic [2:0]        state_dbg
);

    boot_state_t state, state_n;

    logic [31:0] len;
    logic [31:0] csum;
    logic [31:0] timer;
    logic [31:0] rel_cnt;

    logic        wv;
    logic [31:0] w;
    logic        counting;
    logic        timed_out;
    logic        last_word;

    assign wv = uart.io_word_valid;
    assign w  = uart.io_word_packet;

    assign counting = (state == BOOT_LEN) ||
                      (state == BOOT_LOAD) ||
                      (state == BOOT_CHECK);

    // An arriving word beats an expiring timer.
    assign timed_out = counting && !wv &&
                       (timer == TIMEOUT - 1);

    assign last_word =
        ({16'd0, words_loaded} + 32'd1) == len;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            BOOT_IDLE: begin
                if (wv && w == MAGIC)
                    state_n = BOOT_LEN;
            end
            BOOT_LEN: begin
                if (wv) begin
                    if (w == 32'd0 || w > DEPTH_WORDS)
                        state_n = BOOT_ERROR;
                    else
                        state_n = BOOT_LOAD;
                end
            end
            BOOT_LOAD: begin
                if (wv && last_word)
                    state_n = BOOT_CHECK;
            end
            BOOT_CHECK: begin
                if (wv)
                    state_n = (w == csum) ? BOOT_RELEASE
                                          : BOOT_ERROR;
            end
            BOOT_RELEASE: begin
                if (rel_cnt == REL_DELAY - 1)
                    state_n = BOOT_RUN;
            end
            BOOT_RUN, BOOT_ERROR: begin
                if (wv && w == MAGIC)
                    state_n = BOOT_LEN;
            end
            default: state_n = BOOT_IDLE;
        endcase
        if (timed_out)
            state_n = BOOT_ERROR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_en       <= 1'b0;
            imem_data_in  <= 32'd0;
            write_address <= BASE;
            cpu_rstn      <= 1'b0;
            load_busy     <= 1'b0;
            load_error    <= 1'b0;
            words_loaded  <= 16'd0;
            len           <= 32'd0;
            csum          <= 32'd0;
            timer         <= 32'd0;
            rel_cnt       <= 32'd0;
        end else begin
            imem_en <= 1'b0;

            if (state == BOOT_LEN && wv) begin
                len <= w;
                if (state_n == BOOT_LOAD) begin
                    csum         <= 32'd0;
                    words_loaded <= 16'd0;
                end
            end

            if (state == BOOT_LOAD && wv) begin
                imem_en       <= 1'b1;
                imem_data_in  <= w;
                write_address <= BASE +
                    {14'd0, words_loaded, 2'b00};
                csum          <= csum + w;
                words_loaded  <= words_loaded + 16'd1;
            end

            if (wv || !counting)
                timer <= 32'd0;
            else
                timer <= timer + 32'd1;

            if (state == BOOT_RELEASE)
                rel_cnt <= rel_cnt + 32'd1;
            else
                rel_cnt <= 32'd0;

            cpu_rstn   <= (state_n == BOOT_RUN);
            load_error <= (state_n == BOOT_ERROR);
            load_busy  <= (state_n == BOOT_LEN) ||
                          (state_n == BOOT_LOAD) ||
                          (state_n == BOOT_CHECK) ||
                          (state_n == BOOT_RELEASE);
        end
    end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Directed bench for uart_boot_ctrl: framing, checksum,
// length bounds, timeout, reload and async reset.
module tb_uart_boot_ctrl;

    localparam logic [31:0] MG = 32'hB007_10AD;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_REL  = 3'd4;
    localparam logic [2:0] S_RUN  = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_en;
    logic [31:0] imem_data_in;
    logic [31:0] write_address;
    logic        cpu_rstn;
    logic        load_busy;
    logic        load_error;
    logic [15:0] words_loaded;
    logic [2:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    uart_boot_ctrl_if u_if ();

    uart_boot_ctrl #(
        .TIMEOUT (100)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .uart          (u_if),
        .imem_en       (imem_en),
        .imem_data_in  (imem_data_in),
        .write_address (write_address),
        .cpu_rstn      (cpu_rstn),
        .load_busy     (load_busy),
        .load_error    (load_error),
        .words_loaded  (words_loaded),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (imem_en) begin
            wr_addr.push_back(write_address);
            wr_data.push_back(imem_data_in);
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h",
                     tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        u_if.io_word_valid  = 1'b1;
        u_if.io_word_packet = w;
        @(negedge clk);
        u_if.io_word_valid  = 1'b0;
        u_if.io_word_packet = 32'd0;
    endtask

    task automatic clr_wr();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic chk_wr(input string tag, input int n,
                          input logic [31:0] d0,
                          input logic [31:0] d1,
                          input logic [31:0] d2);
        logic [31:0] d[3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        chk({tag, "_n"}, wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            chk({tag, "_a"}, wr_addr[i], 32'(4 * i));
            chk({tag, "_d"}, wr_data[i], d[i]);
        end
    endtask

    // Checksum word was just taken; CPU leaves reset 16 edges later.
    task automatic chk_release(input string tag);
        chk({tag, "_rel"}, state_dbg, S_REL);
        repeat (15) @(negedge clk);
        chk({tag, "_rst15"}, cpu_rstn, 1'b0);
        @(negedge clk);
        chk({tag, "_rst16"}, cpu_rstn, 1'b1);
        chk({tag, "_run"}, state_dbg, S_RUN);
        chk({tag, "_busy"}, load_busy, 1'b0);
    endtask

    initial begin
        u_if.io_word_valid  = 1'b0;
        u_if.io_word_packet = 32'd0;
        repeat (2) @(negedge clk);

        chk("rst_state", state_dbg, S_IDLE);
        chk("rst_rstn", cpu_rstn, 1'b0);
        chk("rst_en", imem_en, 1'b0);
        chk("rst_addr", write_address, 32'd0);
        chk("rst_wl", words_loaded, 16'd0);
        reset_n = 1'b1;

        // Non-magic words are ignored while idle.
        send(32'h1234_5678);
        chk("idle_ign", state_dbg, S_IDLE);

        // T1
        clr_wr();
        send(MG);
        chk("t1_len", state_dbg, S_LEN);
        chk("t1_busy", load_busy, 1'b1);
        send(32'd3);
        chk("t1_load", state_dbg, S_LOAD);
        send(32'h11);
        send(32'h22);
        send(32'h33);
        chk("t1_wl", words_loaded, 16'd3);
        send(32'h66);
        chk_wr("t1_wr", 3, 32'h11, 32'h22, 32'h33);
        chk_release("t1");

        // T2
        send(MG);
        send(32'd2);
        send(32'hA);
        send(32'hB);
        send(32'h0);
        chk("t2_err", load_error, 1'b1);
        chk("t2_rstn", cpu_rstn, 1'b0);
        chk("t2_state", state_dbg, S_ERR);
        send(MG);
        send(32'd1);
        send(32'h5);
        send(32'h5);
        chk("t2_errclr", load_error, 1'b0);
        chk_release("t2");

        // T3
        clr_wr();
        send(MG);
        send(32'd0);
        chk("t3_zero", state_dbg, S_ERR);
        send(MG);
        send(32'd257);
        chk("t3_big", state_dbg, S_ERR);
        chk("t3_nowr", wr_addr.size(), 0);

        // T4
        send(MG);
        send(32'd4);
        send(32'h1);
        repeat (99) @(negedge clk);
        chk("t4_pre", state_dbg, S_LOAD);
        @(negedge clk);
        chk("t4_to", state_dbg, S_ERR);
        chk("t4_err", load_error, 1'b1);
        chk("t4_wl", words_loaded, 16'd1);

        // T5
        send(MG);
        send(32'd2);
        send(32'h3);
        send(32'h4);
        send(32'h7);
        chk_release("t5a");
        clr_wr();
        send(MG);
        chk("t5_drop", cpu_rstn, 1'b0);
        chk("t5_len", state_dbg, S_LEN);
        send(32'd1);
        send(32'h7);
        send(32'h7);
        chk_wr("t5_wr", 1, 32'h7, 32'h0, 32'h0);
        chk_release("t5b");

        // T6
        send(MG);
        send(32'd4);
        send(32'h10);
        @(negedge clk);
        u_if.io_word_valid  = 1'b1;
        u_if.io_word_packet = 32'h20;
        #2 reset_n = 1'b0;
        #1;
        chk("t6_state", state_dbg, S_IDLE);
        chk("t6_wl", words_loaded, 16'd0);
        chk("t6_addr", write_address, 32'd0);
        chk("t6_data", imem_data_in, 32'd0);
        chk("t6_busy", load_busy, 1'b0);
        chk("t6_rstn", cpu_rstn, 1'b0);
        u_if.io_word_valid  = 1'b0;
        u_if.io_word_packet = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        clr_wr();
        send(MG);
        send(32'd2);
        send(32'hA);
        send(32'hB);
        send(32'h15);
        chk_wr("t6_wr", 2, 32'hA, 32'hB, 32'h0);
        chk_release("t6");

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
